piso_new_serializer: RTL and testbench
======================================

# piso_new_serializer

Parallel-in/serial-out converter for the PE array output path. Captures one wide word holding one complex sample (I/Q, 2×DATA_WIDTH) per PE. Streams the samples one per clock onto a single PE-width bus, with a valid strobe. It sits between the PE array's parallel result bus and the single-lane output stream.

## Interface
Parameters:
- PE_NUM, 4, number of PEs / words per parallel load (from shared parameters header)
- DATA_WIDTH, 16, width of one real component; one serial word is 2*DATA_WIDTH (32 bits by default)

Ports:
- clk  in  1  rising-edge clock; one clock, all state in this domain
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  1 = parallel-load mode, 0 = shift mode
- p_in_v  in  1  p_in valid qualifier; load is honoured only when this is 1
- p_in  in  PE_NUM*2*DATA_WIDTH  parallel word; word k = p_in[(k+1)*W-1 : k*W], W = 2*DATA_WIDTH, k = PE index
- s_out_v  out  1  s_out carries a valid serial word this cycle
- s_out  out  2*DATA_WIDTH  serial output word

## Operation
- Internal state: shift register `shreg` (PE_NUM*W bits) and remaining-word counter `cnt` (0..PE_NUM, $clog2(PE_NUM+1) bits).
- Load (load=1 and p_in_v=1):
  - shreg <= p_in; cnt <= PE_NUM; s_out_v <= 0.
  - Back-to-back loads overwrite; only the last captured word is serialised.
  - A load during an in-progress shift aborts it and restarts with the new data.
- Load requested without valid (load=1, p_in_v=0): no capture, no shift; shreg and cnt hold; s_out_v <= 0.
- Shift (load=0, cnt>0):
  - s_out <= shreg[W-1:0] (word 0, LSB word, first).
  - shreg <= shreg >> W, zero-filled.
  - cnt <= cnt-1; s_out_v <= 1.
  - p_in_v and p_in are ignored in this mode.
- Idle (load=0, cnt==0): s_out_v <= 0; s_out holds its last value; shreg holds.
- Emission order after a load of words w0..w(PE_NUM-1): w0, w1, …, w(PE_NUM-1) on consecutive cycles, then s_out_v drops.
- Data is passed through untouched: no arithmetic, no width change per word.

## Timing
- rst_n=0 (asynchronous, any time): shreg=0, cnt=0, s_out=0, s_out_v=0 immediately. Reset mid-shift discards remaining words.
- Outputs are registered.
- With the load edge at cycle N and load=0 from cycle N+1, word0 appears at the edge of cycle N+1. It is visible after that edge, and s_out_v is high for exactly PE_NUM consecutive cycles.
- Throughput: one parallel word per PE_NUM+1 cycles minimum (1 load + PE_NUM shifts). Any gap of load=1 cycles pauses/restarts as defined above.
- Simultaneous events:
  - Load has priority over shift.
  - Reset has priority over everything.

## Structure
- PE_NUM and DATA_WIDTH come from the shared parameters include/package. Define W = 2*DATA_WIDTH there or as a localparam.
- Single flat module: one always block for shreg/cnt and one for the output registers. No sub-module needed.
- Optional sub-module: `piso_word_mux` if the team prefers a counter-indexed mux over a physical shift. The external behaviour must be identical.

## Test plan
- Reset: hold rst_n=0 with random load/p_in → s_out=0, s_out_v=0. Assert rst_n=0 mid-shift → outputs clear asynchronously and no further valid words appear.
- Single load:
  - Stimulus: p_in=128'h04000000_00040000_00004000_00000004 with load=1, p_in_v=1 for one cycle, then load=0.
  - Required response: s_out = 00000004, 00004000, 00040000, 04000000 on 4 consecutive cycles with s_out_v=1, then s_out_v=0 and s_out holding 04000000.
- Back-to-back loads:
  - Stimulus: loads of …01…, …02…, …03…, …04… (word k = value<<(k*12)) on 4 consecutive cycles, then load=0 while p_in_v stays 1 with changing p_in.
  - Required response: only the 4th word is serialised; p_in changes during shift have no effect.
- Reload mid-shift: load A, shift 2 words, load B for one cycle, then load=0 → A.w0, A.w1, then all 4 words of B.
- load=1, p_in_v=0 during shift → shifting pauses (s_out_v=0), shreg and cnt unchanged. Resumes with the next word when load returns to 0.
- Idle: after the 4 words, keep load=0 for 50 cycles → s_out_v stays 0 and s_out stays stable.

Source files
------------

// File: rtl/piso_new_serializer_pkg.sv
// Shared parameters and mode decode for the PE-array output serializer.
// Mode priority: a valid load, then a load without valid, then shift, then idle.
package piso_new_serializer_pkg;
    localparam int PE_NUM     = 4;
    localparam int DATA_WIDTH = 16;
    localparam int W          = 2 * DATA_WIDTH;
    localparam int P_WIDTH    = PE_NUM * W;
    localparam int CNT_W      = $clog2(PE_NUM + 1);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_HOLD  = 2'd2,
        MODE_SHIFT = 2'd3
    } mode_e;

    function automatic mode_e decode_mode(input logic load, input logic p_in_v, input logic busy);
        mode_e m;
        if (load && p_in_v) begin
            m = MODE_LOAD;
        end else if (load) begin
            m = MODE_HOLD;
        end else if (busy) begin
            m = MODE_SHIFT;
        end else begin
            m = MODE_IDLE;
        end
        return m;
    endfunction
endpackage

// File: rtl/piso_new_serializer.sv
// Parallel-in/serial-out converter: captures PE_NUM complex samples and
// emits them LSB word first, one per clock, with a valid strobe.
module piso_new_serializer
    import piso_new_serializer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               p_in_v,
    input  logic [P_WIDTH-1:0] p_in,
    output logic               s_out_v,
    output logic [W-1:0]       s_out
);

    logic [P_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       s_out_q, s_out_d;
    logic               s_out_v_q, s_out_v_d;
    mode_e              mode_s;

    assign mode_s = decode_mode(load, p_in_v, cnt_q != {CNT_W{1'b0}});

    // Next-state for shift register, word counter and output registers.
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        s_out_d   = s_out_q;
        s_out_v_d = 1'b0;
        case (mode_s)
            MODE_LOAD: begin
                shreg_d = p_in;
                cnt_d   = CNT_W'(PE_NUM);
            end
            MODE_SHIFT: begin
                s_out_d   = shreg_q[W-1:0];
                shreg_d   = shreg_q >> W;
                cnt_d     = cnt_q - CNT_W'(1);
                s_out_v_d = 1'b1;
            end
            MODE_HOLD, MODE_IDLE: begin
                s_out_v_d = 1'b0;
            end
            default: begin
                s_out_v_d = 1'b0;
            end
        endcase
    end

    // Shift register and remaining-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= {P_WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered serial outputs; s_out keeps its last word when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_out_q   <= {W{1'b0}};
            s_out_v_q <= 1'b0;
        end else begin
            s_out_q   <= s_out_d;
            s_out_v_q <= s_out_v_d;
        end
    end

    assign s_out   = s_out_q;
    assign s_out_v = s_out_v_q;

endmodule

// File: tb/tb_piso_new_serializer.sv
// Self-checking bench: directed table, hand-written corner sequences and random
// traffic compared against a queue-based model of the serializer.
module tb_piso_new_serializer;
    import piso_new_serializer_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               load = 1'b0;
    logic               p_in_v = 1'b0;
    logic [P_WIDTH-1:0] p_in = '0;
    logic               s_out_v;
    logic [W-1:0]       s_out;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending words queue plus the last emitted word.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_out = '0;
    logic         m_v = 1'b0;

    typedef struct {
        logic               ld;
        logic               vld;
        logic [P_WIDTH-1:0] p;
        logic               exp_v;
        logic [W-1:0]       exp_out;
    } vec_t;

    vec_t tbl[7];

    piso_new_serializer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .p_in_v  (p_in_v),
        .p_in    (p_in),
        .s_out_v (s_out_v),
        .s_out   (s_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_out = '0;
        m_v   = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic v, input logic [P_WIDTH-1:0] p);
        if (l && v) begin
            m_q.delete();
            for (int k = 0; k < PE_NUM; k++) m_q.push_back(p[k*W +: W]);
            m_v = 1'b0;
        end else if (l) begin
            m_v = 1'b0;
        end else if (m_q.size() > 0) begin
            m_out = m_q.pop_front();
            m_v   = 1'b1;
        end else begin
            m_v = 1'b0;
        end
    endtask

    // Called at a negedge: drive inputs, clock once, return at next negedge.
    task automatic drive(input logic l, input logic v, input logic [P_WIDTH-1:0] p);
        load   = l;
        p_in_v = v;
        p_in   = p;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(l, v, p);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic ev, input logic [W-1:0] eo);
        vectors++;
        if (s_out_v !== ev || s_out !== eo) begin
            miscompares++;
            $display("FAIL %s: got v=%0b out=%h, want v=%0b out=%h", name, s_out_v, s_out, ev, eo);
        end
    endtask

    task automatic step_chk(input string name, input logic l, input logic v, input logic [P_WIDTH-1:0] p);
        drive(l, v, p);
        chk(name, m_v, m_out);
    endtask

    function automatic logic [P_WIDTH-1:0] mk(input int val);
        logic [P_WIDTH-1:0] r;
        logic [W-1:0] w;
        r = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            w = W'(val) << (k * 12);
            r[k*W +: W] = w;
        end
        return r;
    endfunction

    function automatic logic [P_WIDTH-1:0] rnd_p();
        logic [P_WIDTH-1:0] r;
        for (int k = 0; k < PE_NUM; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    initial begin
        logic [P_WIDTH-1:0] pa, pb;
        pa = 128'h04000000_00040000_00004000_00000004;
        tbl[0] = '{1'b1, 1'b1, pa,   1'b0, 32'h00000000};
        tbl[1] = '{1'b0, 1'b0, '0,   1'b1, 32'h00000004};
        tbl[2] = '{1'b0, 1'b0, '0,   1'b1, 32'h00004000};
        tbl[3] = '{1'b0, 1'b0, '0,   1'b1, 32'h00040000};
        tbl[4] = '{1'b0, 1'b0, '0,   1'b1, 32'h04000000};
        tbl[5] = '{1'b0, 1'b0, '0,   1'b0, 32'h04000000};
        tbl[6] = '{1'b0, 1'b0, '0,   1'b0, 32'h04000000};

        // Reset held with random inputs
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_p());
            chk("reset_hold", 1'b0, 32'h0);
        end
        rst_n = 1'b1;

        // Directed single-load table
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].ld, tbl[i].vld, tbl[i].p);
            chk($sformatf("single_load[%0d]", i), tbl[i].exp_v, tbl[i].exp_out);
        end

        // Back-to-back loads, then changing p_in during shift
        for (int i = 1; i <= 4; i++) step_chk("b2b_load", 1'b1, 1'b1, mk(i));
        for (int i = 0; i < 6; i++) step_chk("b2b_shift", 1'b0, 1'b1, rnd_p());

        // Reload mid-shift
        pa = rnd_p();
        pb = rnd_p();
        step_chk("reload_a", 1'b1, 1'b1, pa);
        step_chk("reload_a0", 1'b0, 1'b0, '0);
        chk("reload_a0_val", 1'b1, pa[W-1:0]);
        step_chk("reload_a1", 1'b0, 1'b0, '0);
        step_chk("reload_b", 1'b1, 1'b1, pb);
        for (int i = 0; i < PE_NUM; i++) begin
            step_chk("reload_bw", 1'b0, 1'b0, '0);
            chk("reload_bw_val", 1'b1, pb[i*W +: W]);
        end
        step_chk("reload_end", 1'b0, 1'b0, '0);

        // Load without valid pauses the shift
        pa = rnd_p();
        step_chk("pause_load", 1'b1, 1'b1, pa);
        step_chk("pause_w0", 1'b0, 1'b0, '0);
        step_chk("pause_hold", 1'b1, 1'b0, rnd_p());
        chk("pause_hold_val", 1'b0, pa[W-1:0]);
        step_chk("pause_hold2", 1'b1, 1'b0, rnd_p());
        step_chk("pause_w1", 1'b0, 1'b0, '0);
        chk("pause_w1_val", 1'b1, pa[W +: W]);
        for (int i = 0; i < 3; i++) step_chk("pause_rest", 1'b0, 1'b0, '0);

        // Idle for 50 cycles
        for (int i = 0; i < 50; i++) step_chk("idle", 1'b0, 1'b0, rnd_p());
        chk("idle_hold_val", 1'b0, pa[(PE_NUM-1)*W +: W]);

        // Asynchronous reset mid-shift
        step_chk("rst_mid_load", 1'b1, 1'b1, rnd_p());
        step_chk("rst_mid_w0", 1'b0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 1'b0, 32'h0);
        model_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        chk("rst_low", 1'b0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step_chk("rst_after", 1'b0, 1'b0, '0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step_chk("random", 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), rnd_p());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
